// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, memory and status bundle for dmem_arbiter
//
// Purpose: groups both requester handshakes, the DataMem port and the
// arbiter status outputs so the arbiter and its surroundings connect through
// one object.
//
// Signals:
//   req0/we0/addr0/wdata0  port 0 (CPU) request, level until ack0
//   ack0/rdata0            port 0 one-cycle completion pulse and load result
//   req1/we1/addr1/wdata1  port 1 (DMA/debug) request, level until ack1
//   ack1/rdata1            port 1 completion pulse and load result
//   mem_addr/mem_we/mem_wdata  drive the DataMem instance
//   mem_rdata              combinational read data back from DataMem
//   busy                   arbiter is not idle
//   grant_id               port owning the current (or last) access
//
// Modports: slave = the arbiter, master = requesters plus DataMem side.

interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant_id;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_we, mem_wdata,
        output busy, grant_id
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_we, mem_wdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single-ported DataMem
//
// Purpose: shares one data memory between the CPU load/store path (port 0)
// and the DMA/debug loader (port 1). A winner's request is latched in IDLE,
// exactly one memory access is driven in ACCESS, and a one-cycle ack with a
// registered load result is returned in RESP. One access every 3 cycles.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   dmem_arbiter_if.slave: requester handshakes, DataMem port,
//         busy and grant_id status
//
// Parameters:
//   ADDR_W     address width passed through to memory
//   DATA_W     data width
//   PRIO_MODE  0 = round-robin, 1 = fixed priority with port 0 winning

module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam bit FIXED_PRIO = (PRIO_MODE == 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              rr_last;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              any_req;
    logic              winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Arbitration only matters on a tie; a lone requester always wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        winner  = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = FIXED_PRIO ? 1'b0 : ~rr_last;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    assign win_we    = winner ? bus.we1    : bus.we0;
    assign win_addr  = winner ? bus.addr1  : bus.addr0;
    assign win_wdata = winner ? bus.wdata1 : bus.wdata0;

    // Memory side is driven straight from the latched fields so address and
    // data simply hold their last values between accesses. Gating the write
    // with rst keeps an access aborted by reset from committing.
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_we    = (state == ACCESS) & lat_we & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_last      <= 1'b1;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
            bus.busy     <= 1'b0;
            bus.grant_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    if (any_req) begin
                        lat_we       <= win_we;
                        lat_addr     <= win_addr;
                        lat_wdata    <= win_wdata;
                        bus.grant_id <= winner;
                        rr_last      <= winner;
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end
                end

                ACCESS: begin
                    // The memory read is combinational, so the data seen here
                    // belongs to lat_addr; stores leave rdata untouched.
                    if (!lat_we) begin
                        if (bus.grant_id) begin
                            bus.rdata1 <= bus.mem_rdata;
                        end else begin
                            bus.rdata0 <= bus.mem_rdata;
                        end
                    end
                    bus.ack0 <= ~bus.grant_id;
                    bus.ack1 <= bus.grant_id;
                    state    <= RESP;
                end

                RESP: begin
                    // Requests are deliberately not sampled here; a request
                    // still high next cycle is taken as a fresh one.
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (both arbitration modes)
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut_rr (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_fp (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // DataMem models: combinational read, write on rising edge.
    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    bit init_a;
    bit init_b;

    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[9:2]];
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[9:2]];

    always @(posedge clk) begin
        if (!init_a) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
            init_a <= 1'b1;
        end else if (bus_a.mem_we) begin
            mem_a[bus_a.mem_addr[9:2]] <= bus_a.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (!init_b) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(i);
            init_b <= 1'b1;
        end else if (bus_b.mem_we) begin
            mem_b[bus_b.mem_addr[9:2]] <= bus_b.mem_wdata;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input int p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            bus_a.req0 = req; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wd;
        end else begin
            bus_a.req1 = req; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wd;
        end
    endtask

    task automatic drv_b(input int p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            bus_b.req0 = req; bus_b.we0 = we; bus_b.addr0 = addr; bus_b.wdata0 = wd;
        end else begin
            bus_b.req1 = req; bus_b.we1 = we; bus_b.addr1 = addr; bus_b.wdata1 = wd;
        end
    endtask

    function automatic logic ack_of_a(input int p);
        return (p == 0) ? bus_a.ack0 : bus_a.ack1;
    endfunction

    function automatic logic [31:0] rdata_of_a(input int p);
        return (p == 0) ? bus_a.rdata0 : bus_a.rdata1;
    endfunction

    // One isolated transaction on the round-robin instance, started from IDLE
    // at a falling edge: access in the next cycle, ack in the one after.
    task automatic txn_a(input int p, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        drv_a(p, 1'b1, we, addr, wd);
        @(negedge clk);
        check({tag, "_busy"}, bus_a.busy, 1);
        check({tag, "_grant"}, bus_a.grant_id, p);
        check({tag, "_access_we"}, bus_a.mem_we, we);
        check({tag, "_access_addr"}, bus_a.mem_addr, addr);
        if (we) check({tag, "_access_wdata"}, bus_a.mem_wdata, wd);
        check({tag, "_early_ack"}, {bus_a.ack1, bus_a.ack0}, 0);
        @(negedge clk);
        check({tag, "_ack"}, ack_of_a(p), 1);
        check({tag, "_other_ack"}, ack_of_a(1 - p), 0);
        check({tag, "_resp_we"}, bus_a.mem_we, 0);
        if (!we) check({tag, "_rdata"}, rdata_of_a(p), exp_rd);
        drv_a(p, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, "_ack_drop"}, {bus_a.ack1, bus_a.ack0}, 0);
        check({tag, "_idle_busy"}, bus_a.busy, 0);
        check({tag, "_idle_we"}, bus_a.mem_we, 0);
    endtask

    // Reference model state for the randomized phase.
    logic [31:0] shadow [0:255];
    bit          act [2];
    int          wc [2];
    int          oa [2];
    bit          twe [2];
    logic [31:0] taddr [2];
    logic [31:0] tdata [2];
    logic        av [2];
    logic [31:0] rv [2];

    initial begin
        int idx;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

        rst_a = 1'b1;
        rst_b = 1'b1;
        drv_a(0, 0, 0, 0, 0); drv_a(1, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0); drv_b(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_ack", {bus_a.ack1, bus_a.ack0}, 0);
        check("rst_rdata0", bus_a.rdata0, 0);
        check("rst_rdata1", bus_a.rdata1, 0);
        check("rst_mem_we", bus_a.mem_we, 0);
        check("rst_mem_addr", bus_a.mem_addr, 0);
        check("rst_mem_wdata", bus_a.mem_wdata, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_grant", bus_a.grant_id, 0);
        check("rst_busy_fp", bus_b.busy, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("idle_no_req_busy", bus_a.busy, 0);

        // Single write then read on port 0.
        txn_a(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, "wr0");
        txn_a(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd0");

        // Cross-port coherence: last grant was port 0, so port 1 wins the tie.
        drv_a(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drv_a(1, 1'b1, 1'b1, 32'h40, 32'h0000CAFE);
        @(negedge clk);
        check("coh_grant1", bus_a.grant_id, 1);
        check("coh_write_we", bus_a.mem_we, 1);
        check("coh_write_addr", bus_a.mem_addr, 32'h40);
        @(negedge clk);
        check("coh_ack1", {bus_a.ack1, bus_a.ack0}, 2'b10);
        drv_a(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("coh_gap", {bus_a.ack1, bus_a.ack0}, 0);
        @(negedge clk);
        check("coh_grant0", bus_a.grant_id, 0);
        check("coh_read_we", bus_a.mem_we, 0);
        @(negedge clk);
        check("coh_ack0", {bus_a.ack1, bus_a.ack0}, 2'b01);
        check("coh_rdata0", bus_a.rdata0, 32'h0000CAFE);
        drv_a(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Field changes after the sampling edge are ignored.
        drv_a(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        bus_a.addr0 = 32'h80;
        #1;
        check("chg_mem_addr", bus_a.mem_addr, 32'h10);
        @(negedge clk);
        check("chg_ack0", bus_a.ack0, 1);
        check("chg_rdata0", bus_a.rdata0, 32'hDEADBEEF);
        drv_a(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset during ACCESS aborts the write and suppresses the ack.
        drv_a(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        rst_a = 1'b1;
        drv_a(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rstacc_mem_we", bus_a.mem_we, 0);
        @(negedge clk);
        rst_a = 1'b0;
        check("rstacc_busy", bus_a.busy, 0);
        check("rstacc_ack", {bus_a.ack1, bus_a.ack0}, 0);
        @(negedge clk);
        check("rstacc_no_late_ack", {bus_a.ack1, bus_a.ack0}, 0);
        txn_a(0, 1'b0, 32'h20, 32'h0, init_val(8), "rstacc_rd");

        // Port 1 alone, leaving port 1 as last winner so the next tie goes to 0.
        txn_a(1, 1'b0, 32'h40, 32'h0, 32'h0000CAFE, "rd1");

        // Round-robin contention: grants alternate 0,1,0,1 with acks every 3 cycles.
        drv_a(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drv_a(1, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rr_grant_%0d", k), bus_a.grant_id, k % 2);
            @(negedge clk);
            check($sformatf("rr_ack_%0d", k), {bus_a.ack1, bus_a.ack0}, (k % 2) ? 2'b10 : 2'b01);
            check($sformatf("rr_rdata_%0d", k), rdata_of_a(k % 2),
                  (k % 2) ? 32'h0000CAFE : 32'hDEADBEEF);
            @(negedge clk);
            check($sformatf("rr_gap_%0d", k), {bus_a.ack1, bus_a.ack0}, 0);
        end
        drv_a(0, 0, 0, 0, 0);
        drv_a(1, 0, 0, 0, 0);
        @(negedge clk);
        check("rr_drain_busy", bus_a.busy, 0);

        // Fixed priority: port 0 keeps winning until it drops its request.
        drv_b(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drv_b(1, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fp_grant_%0d", k), bus_b.grant_id, 0);
            @(negedge clk);
            check($sformatf("fp_ack_%0d", k), {bus_b.ack1, bus_b.ack0}, 2'b01);
            check($sformatf("fp_rdata_%0d", k), bus_b.rdata0, init_val(4));
            @(negedge clk);
        end
        drv_b(0, 0, 0, 0, 0);
        @(negedge clk);
        check("fp_grant_p1", bus_b.grant_id, 1);
        @(negedge clk);
        check("fp_ack_p1", {bus_b.ack1, bus_b.ack0}, 2'b10);
        check("fp_rdata_p1", bus_b.rdata1, init_val(8));
        drv_b(1, 0, 0, 0, 0);
        @(negedge clk);

        // Randomized traffic on the round-robin instance against a
        // transaction-level model: serialized accesses, shadow memory,
        // bounded latency and at most one foreign access per wait.
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; wc[p] = 0; oa[p] = 0;
        end
        for (int cyc = 0; cyc < 450; cyc++) begin
            @(negedge clk);
            av[0] = bus_a.ack0; av[1] = bus_a.ack1;
            rv[0] = bus_a.rdata0; rv[1] = bus_a.rdata1;
            check("rand_ack_onehot", av[0] & av[1], 0);
            for (int p = 0; p < 2; p++) begin
                if (act[p]) wc[p]++;
                check("rand_spurious_ack", av[p] & ~act[p], 0);
                if (act[p]) check("rand_timeout", (wc[p] > 8), 0);
                if (av[p] && act[p]) begin
                    check("rand_latency", (wc[p] <= 6), 1);
                    check("rand_fairness", (oa[p] <= 1), 1);
                    idx = int'(taddr[p][9:2]);
                    if (twe[p]) shadow[idx] = tdata[p];
                    else check("rand_rdata", rv[p], shadow[idx]);
                    act[p] = 1'b0;
                    if (act[1 - p]) oa[1 - p]++;
                end else if (act[p] && wc[p] > 8) begin
                    act[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && cyc < 300 && $urandom_range(0, 1) == 1) begin
                    act[p]   = 1'b1;
                    wc[p]    = 0;
                    oa[p]    = 0;
                    twe[p]   = ($urandom_range(0, 1) == 1);
                    taddr[p] = 32'h100 + (32'($urandom_range(0, 7)) << 2);
                    tdata[p] = $urandom;
                    drv_a(p, 1'b1, twe[p], taddr[p], tdata[p]);
                end else if (!act[p]) begin
                    drv_a(p, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            if (cyc >= 300 && !act[0] && !act[1]) break;
        end
        check("rand_drained", act[0] | act[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (DataMem/DRAM: combinational read, write committed on `clk` rising edge) between two requesters.
  - Port 0: CPU load/store path.
  - Port 1: DMA/debug loader.
- Latches each winner's request, then drives exactly one memory access.
- Returns a registered read result with a one-cycle ack pulse.
- Sits between the requesters and the DataMem instance.

Parameters:
- ADDR_W, 32, address width passed through to memory.
- DATA_W, 32, data width.
- PRIO_MODE, 0, arbitration policy.
  - 0: round-robin.
  - 1: fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request (level).
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  ADDR_W  port 0 byte address.
- wdata0  in  DATA_W  port 0 store data.
- ack0  out  1  port 0 completion pulse.
- rdata0  out  DATA_W  port 0 load result; valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_addr  out  ADDR_W  to DataMem addr.
- mem_we  out  1  to DataMem we.
- mem_wdata  out  DATA_W  to DataMem wdata.
- mem_rdata  in  DATA_W  from DataMem rdata (combinational).
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  port currently owning the access; held from the previous grant when idle.

Behaviour:
- Reset values:
  - state = IDLE.
  - ack0 = ack1 = 0.
  - rdata0 = rdata1 = 0.
  - mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - busy = 0; grant_id = 0.
  - rr_last = 1, so port 0 wins the first round-robin tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples req0/req1 each edge.
  - If either is high:
    - Pick the winner.
    - Latch its we, addr and wdata into lat_we, lat_addr, lat_wdata.
    - Set grant_id to the winner; go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration when both requests are high:
  - PRIO_MODE=0: winner = !rr_last; rr_last is updated to the winner on every grant.
  - PRIO_MODE=1: port 0 always wins.
  - A single requester always wins regardless of mode.
- ACCESS (exactly 1 cycle):
  - mem_addr = lat_addr and mem_wdata = lat_wdata.
  - mem_we = lat_we & ~rst.
  - At the closing edge:
    - DataMem commits any write.
    - mem_rdata is captured into the winner's rdata register (loads only; rdata unchanged on stores).
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - ack[grant_id] = 1; the other ack stays 0.
  - Next state is IDLE.
  - Requests are not sampled in RESP.
- mem_addr, mem_wdata and mem_we are combinational from state and latched fields.
  - Outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold their last latched values.
- Latency and throughput:
  - Request sampled at edge E0 → write commits / read captured at E1 → ack high in the cycle after E1.
  - One access per 3 cycles; maximum wait for the losing port in round-robin is one access (3 cycles).
- Requester handshake rules:
  - Hold req, we, addr and wdata stable until ack.
  - Changes after the IDLE sampling edge are ignored; fields are latched.
  - req still high in the cycle after ack is treated as a new request.
- Addresses are passed unmodified; alignment is the requester's responsibility.
- Port 0 and port 1 targeting the same address resolve strictly in grant order.
  - A port-1 read following a port-0 write returns the written value.
- Reset mid-operation:
  - rst high in ACCESS forces mem_we = 0 in that same cycle, so no write is committed.
  - All state returns to reset values at that edge; no ack is issued for the aborted access.
- Both ack outputs are never high together; ack is never high for a port without a preceding grant.

Test Plan:
- Single write then read:
  - Port 0 write addr=0x10, wdata=0xDEADBEEF, then read addr=0x10.
  - Each transaction: ack0 pulses exactly 1 cycle, 2 cycles after the request is sampled.
  - The read returns rdata0=0xDEADBEEF; mem_we high only in the write's ACCESS cycle.
- Round-robin contention:
  - PRIO_MODE=0; req0 and req1 held high continuously, both reads.
  - Grants alternate 0,1,0,1; acks every 3 cycles, alternating ports.
- Fixed-priority contention:
  - PRIO_MODE=1; both requests held high.
  - Port 0 granted every access; port 1 acks only after req0 drops.
- Cross-port coherence:
  - Port 1 writes 0x0000CAFE to addr=0x40 while port 0 simultaneously reads 0x40 (round-robin, rr_last=0 so port 1 wins).
  - Port 0 then receives rdata0=0x0000CAFE.
- Reset during ACCESS:
  - Port 0 write addr=0x20, wdata=0x12345678; assert rst in the ACCESS cycle.
  - No ack0; a later read of 0x20 returns the prior contents; busy=0 the cycle after reset.
- Request field changes after grant:
  - Change addr0 from 0x10 to 0x80 the cycle after IDLE samples it.
  - The access still targets 0x10.
